// File: rtl/obi_addr_demux_tracked.sv
// obi_addr_demux_tracked: OBI address demux with outstanding tracking, in-order target switching and error responder
module obi_addr_demux_tracked #(
  parameter int NumMgrPorts  = 4,
  parameter int NumAddrRules = 4,
  parameter int AddrWidth    = 32,
  parameter int DataWidth    = 32,
  parameter int IdWidth      = 1,
  parameter int NumMaxTrans  = 4,
  localparam int CntW = $clog2(NumMaxTrans + 1),
  localparam int IdxW = $clog2(NumMgrPorts)
) (
  input  logic                                    clk_i,
  input  logic                                    rst_i,
  input  logic                                    sbr_req_i,
  input  logic [AddrWidth-1:0]                    sbr_addr_i,
  input  logic                                    sbr_we_i,
  input  logic [DataWidth/8-1:0]                  sbr_be_i,
  input  logic [DataWidth-1:0]                    sbr_wdata_i,
  input  logic [IdWidth-1:0]                      sbr_aid_i,
  output logic                                    sbr_gnt_o,
  output logic                                    sbr_rvalid_o,
  output logic                                    sbr_err_o,
  output logic [DataWidth-1:0]                    sbr_rdata_o,
  output logic [IdWidth-1:0]                      sbr_rid_o,
  output logic [NumMgrPorts-1:0]                  mgr_req_o,
  output logic [AddrWidth-1:0]                    mgr_addr_o,
  output logic                                    mgr_we_o,
  output logic [DataWidth/8-1:0]                  mgr_be_o,
  output logic [DataWidth-1:0]                    mgr_wdata_o,
  output logic [IdWidth-1:0]                      mgr_aid_o,
  input  logic [NumMgrPorts-1:0]                  mgr_gnt_i,
  input  logic [NumMgrPorts-1:0]                  mgr_rvalid_i,
  input  logic [NumMgrPorts-1:0]                  mgr_err_i,
  input  logic [NumMgrPorts-1:0][DataWidth-1:0]   mgr_rdata_i,
  input  logic [NumMgrPorts-1:0][IdWidth-1:0]     mgr_rid_i,
  input  logic [NumAddrRules-1:0][IdxW-1:0]       rule_idx_i,
  input  logic [NumAddrRules-1:0][AddrWidth-1:0]  rule_start_i,
  input  logic [NumAddrRules-1:0][AddrWidth-1:0]  rule_end_i,
  input  logic                                    en_default_idx_i,
  input  logic [IdxW-1:0]                         default_idx_i,
  output logic                                    busy_o,
  output logic [CntW-1:0]                         outstanding_o,
  output logic                                    dec_err_o
);
  localparam logic [CntW-1:0] MaxCnt = CntW'(NumMaxTrans);
  logic [CntW-1:0] r_cnt;
  logic [IdxW-1:0] r_sel_idx;
  logic            r_sel_err;
  logic            r_err_pend;
  logic [IdWidth-1:0] r_err_id;
  logic            w_match;
  logic [IdxW-1:0] w_rule_idx;
  logic [IdxW-1:0] w_tgt_idx;
  logic            w_tgt_err;
  logic            w_cnt_zero;
  logic            w_rsp_port;
  logic            w_rsp;
  logic            w_allow;
  logic            w_acc;
  // reverse scan so the lowest matching rule is the one left standing
  always_comb begin
    w_match    = 1'b0;
    w_rule_idx = '0;
    for (int r = NumAddrRules - 1; r >= 0; r--)
      if (rule_start_i[r] <= sbr_addr_i && sbr_addr_i < rule_end_i[r]) begin
        w_match    = 1'b1;
        w_rule_idx = rule_idx_i[r];
      end
  end
  assign w_tgt_err  = !w_match && !en_default_idx_i;
  assign w_tgt_idx  = w_match ? w_rule_idx : default_idx_i;
  assign w_cnt_zero = r_cnt == '0;
  assign w_rsp_port = !w_cnt_zero && !r_sel_err && mgr_rvalid_i[r_sel_idx];
  assign w_rsp      = w_rsp_port || r_err_pend;
  // a freed slot in the same cycle lets a same-target request through even when full
  assign w_allow    = !rst_i && (w_cnt_zero || (!w_tgt_err && !r_sel_err &&
                      w_tgt_idx == r_sel_idx && (r_cnt < MaxCnt || w_rsp)));
  assign sbr_gnt_o  = w_allow && (w_tgt_err ? sbr_req_i : mgr_gnt_i[w_tgt_idx]);
  assign w_acc      = sbr_req_i && sbr_gnt_o;
  assign mgr_req_o  = (w_allow && !w_tgt_err && sbr_req_i) ? NumMgrPorts'(1) << w_tgt_idx : '0;
  assign dec_err_o  = w_acc && w_tgt_err;
  assign mgr_addr_o  = sbr_addr_i;
  assign mgr_we_o    = sbr_we_i;
  assign mgr_be_o    = sbr_be_i;
  assign mgr_wdata_o = sbr_wdata_i;
  assign mgr_aid_o   = sbr_aid_i;
  assign sbr_rvalid_o  = !rst_i && w_rsp;
  assign sbr_err_o     = !rst_i && (r_err_pend || (w_rsp_port && mgr_err_i[r_sel_idx]));
  assign sbr_rdata_o   = r_err_pend ? '0 : mgr_rdata_i[r_sel_idx];
  assign sbr_rid_o     = r_err_pend ? r_err_id : mgr_rid_i[r_sel_idx];
  assign busy_o        = !rst_i && !w_cnt_zero;
  assign outstanding_o = rst_i ? '0 : r_cnt;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt      <= '0;
      r_sel_idx  <= '0;
      r_sel_err  <= 1'b0;
      r_err_pend <= 1'b0;
      r_err_id   <= '0;
    end else begin
      r_cnt      <= r_cnt + CntW'(w_acc) - CntW'(w_rsp);
      r_err_pend <= dec_err_o;
      if (w_acc) begin
        r_sel_idx <= w_tgt_idx;
        r_sel_err <= w_tgt_err;
      end
      if (dec_err_o) r_err_id <= sbr_aid_i;
    end
  end
endmodule

// File: tb/tb_obi_addr_demux_tracked.sv
// tb_obi_addr_demux_tracked: directed stimulus with a response scoreboard for obi_addr_demux_tracked
module tb_obi_addr_demux_tracked;
  logic clk = 0, rst;
  logic sbr_req, sbr_we, sbr_gnt, sbr_rvalid, sbr_err, mgr_we, en_def, busy, dec_err;
  logic [31:0] sbr_addr, sbr_wdata, sbr_rdata, mgr_addr, mgr_wdata;
  logic [3:0] sbr_be, mgr_be, mgr_req, mgr_gnt, mgr_rvalid, mgr_err;
  logic [0:0] sbr_aid, sbr_rid, mgr_aid;
  logic [3:0][31:0] mgr_rdata;
  logic [3:0][0:0] mgr_rid;
  logic [3:0][1:0] rule_idx;
  logic [3:0][31:0] rule_start, rule_end;
  logic [1:0] def_idx, outstanding;
  int checks = 0, errors = 0;
  typedef struct {logic [31:0] d; logic e; logic id;} exp_t;
  exp_t sb[$];

  obi_addr_demux_tracked #(.NumMaxTrans(2)) dut (
    .clk_i(clk), .rst_i(rst), .sbr_req_i(sbr_req), .sbr_addr_i(sbr_addr), .sbr_we_i(sbr_we),
    .sbr_be_i(sbr_be), .sbr_wdata_i(sbr_wdata), .sbr_aid_i(sbr_aid), .sbr_gnt_o(sbr_gnt),
    .sbr_rvalid_o(sbr_rvalid), .sbr_err_o(sbr_err), .sbr_rdata_o(sbr_rdata), .sbr_rid_o(sbr_rid),
    .mgr_req_o(mgr_req), .mgr_addr_o(mgr_addr), .mgr_we_o(mgr_we), .mgr_be_o(mgr_be),
    .mgr_wdata_o(mgr_wdata), .mgr_aid_o(mgr_aid), .mgr_gnt_i(mgr_gnt), .mgr_rvalid_i(mgr_rvalid),
    .mgr_err_i(mgr_err), .mgr_rdata_i(mgr_rdata), .mgr_rid_i(mgr_rid), .rule_idx_i(rule_idx),
    .rule_start_i(rule_start), .rule_end_i(rule_end), .en_default_idx_i(en_def),
    .default_idx_i(def_idx), .busy_o(busy), .outstanding_o(outstanding), .dec_err_o(dec_err));

  always #5 clk = ~clk;

  task automatic chk(string n, logic [63:0] a, logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", n, a, e);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic rsp(int p, logic [31:0] d, logic e, logic id, bit track);
    mgr_rvalid = '0;
    mgr_err = '0;
    mgr_rvalid[p] = 1'b1;
    mgr_rdata[p] = d;
    mgr_err[p] = e;
    mgr_rid[p] = id;
    if (track) sb.push_back('{d, e, id});
  endtask

  always @(negedge clk) begin
    if (sbr_rvalid) begin
      if (sb.size() == 0) chk("unexpected_rvalid", 1, 0);
      else begin
        exp_t x;
        x = sb.pop_front();
        chk("rdata", sbr_rdata, x.d);
        chk("rerr", sbr_err, x.e);
        chk("rid", sbr_rid, x.id);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    rst = 1; sbr_req = 0; sbr_addr = 0; sbr_we = 0; sbr_be = 4'hF; sbr_wdata = 32'h5A5A_0000;
    sbr_aid = 0; mgr_gnt = 4'hF; mgr_rvalid = 0; mgr_err = 0; mgr_rdata = '0; mgr_rid = '0;
    en_def = 0; def_idx = 0;
    rule_start = {32'h0, 32'h2000, 32'h1000, 32'h0};
    rule_end   = {32'h4000, 32'h3000, 32'h2000, 32'h1000};
    rule_idx   = {2'd3, 2'd2, 2'd0, 2'd1};
    cyc(); sbr_req = 1; sbr_addr = 32'h10;
    @(negedge clk);
    chk("rst_gnt", sbr_gnt, 0); chk("rst_mgr_req", mgr_req, 0); chk("rst_busy", busy, 0);
    chk("rst_outstanding", outstanding, 0); chk("rst_dec_err", dec_err, 0);
    cyc(); rst = 0; mgr_gnt = 0; sbr_addr = 32'h0FFF;
    @(negedge clk); chk("dec_0fff", mgr_req, 4'b0010); chk("dec_no_gnt", sbr_gnt, 0);
    cyc(); sbr_addr = 32'h1000;
    @(negedge clk); chk("dec_1000", mgr_req, 4'b0001);
    cyc(); sbr_addr = 32'h3000;
    @(negedge clk); chk("dec_3000", mgr_req, 4'b1000);
    cyc(); sbr_addr = 32'h2FFF;
    @(negedge clk); chk("dec_2fff", mgr_req, 4'b0100);
    // single read to port 1
    cyc(); mgr_gnt = 4'hF; sbr_addr = 32'h10;
    @(negedge clk); chk("t1_req", mgr_req, 4'b0010); chk("t1_gnt", sbr_gnt, 1); chk("t1_out0", outstanding, 0);
    cyc(); sbr_req = 0;
    @(negedge clk); chk("t1_out1", outstanding, 1); chk("t1_busy", busy, 1);
    cyc(); rsp(1, 32'hCAFE_0001, 0, 1, 1);
    @(negedge clk); chk("t1_out_rsp", outstanding, 1);
    cyc(); mgr_rvalid = 0;
    @(negedge clk); chk("t1_out_end", outstanding, 0); chk("t1_idle", busy, 0);
    // fill to NumMaxTrans=2 on port 0
    cyc(); sbr_req = 1; sbr_addr = 32'h1000;
    @(negedge clk); chk("t2_gnt_a", sbr_gnt, 1);
    cyc();
    @(negedge clk); chk("t2_gnt_b", sbr_gnt, 1); chk("t2_out1", outstanding, 1);
    cyc();
    @(negedge clk); chk("t2_full_gnt", sbr_gnt, 0); chk("t2_full_req", mgr_req, 0); chk("t2_out2", outstanding, 2);
    cyc(); rsp(0, 32'hD000_0001, 0, 0, 1);
    @(negedge clk); chk("t2_gnt_at_rsp", sbr_gnt, 1);
    cyc(); sbr_req = 0; rsp(0, 32'hD000_0002, 1, 1, 1);
    @(negedge clk); chk("t2_out_keep", outstanding, 2);
    cyc(); rsp(0, 32'hD000_0003, 0, 0, 1);
    @(negedge clk); chk("t2_out_dec", outstanding, 1);
    cyc(); mgr_rvalid = 0;
    @(negedge clk); chk("t2_out_end", outstanding, 0);
    // target switch port 0 -> port 2
    cyc(); sbr_req = 1; sbr_addr = 32'h1000;
    @(negedge clk); chk("t3_gnt0", sbr_gnt, 1);
    cyc(); sbr_addr = 32'h2000;
    @(negedge clk); chk("t3_stall_req", mgr_req, 0); chk("t3_stall_gnt", sbr_gnt, 0);
    cyc(); rsp(0, 32'hD000_0004, 0, 0, 1);
    @(negedge clk); chk("t3_stall_rsp", mgr_req, 0);
    cyc(); mgr_rvalid = 0;
    @(negedge clk); chk("t3_issue_req", mgr_req, 4'b0100); chk("t3_issue_gnt", sbr_gnt, 1);
    cyc(); sbr_req = 0; rsp(2, 32'hD000_0005, 0, 1, 1); mgr_rvalid[0] = 1; mgr_rdata[0] = 32'hBAD0_0000;
    cyc(); mgr_rvalid = 0;
    @(negedge clk); chk("t3_out_end", outstanding, 0);
    // unmapped address -> internal error responder
    cyc(); sbr_req = 1; sbr_addr = 32'hFFFF_0000; sbr_aid = 1; sb.push_back('{32'h0, 1'b1, 1'b1});
    @(negedge clk); chk("t4_gnt", sbr_gnt, 1); chk("t4_dec_err", dec_err, 1); chk("t4_no_req", mgr_req, 0);
    cyc(); sbr_req = 0;
    @(negedge clk); chk("t4_dec_err_pulse", dec_err, 0);
    // same address through the default port
    cyc(); sbr_req = 1; sbr_aid = 0; en_def = 1; def_idx = 3;
    @(negedge clk); chk("t5_req", mgr_req, 4'b1000); chk("t5_no_dec_err", dec_err, 0); chk("t5_gnt", sbr_gnt, 1);
    cyc(); sbr_req = 0; rsp(3, 32'hD000_0006, 0, 0, 1);
    cyc(); mgr_rvalid = 0; en_def = 0;
    // mid-operation reset drops late responses
    cyc(); sbr_req = 1; sbr_addr = 32'h1000;
    cyc();
    cyc(); sbr_req = 0;
    @(negedge clk); chk("t6_out2", outstanding, 2);
    cyc(); rst = 1;
    @(negedge clk); chk("t6_rst_out", outstanding, 0); chk("t6_rst_busy", busy, 0);
    cyc(); rst = 0; rsp(0, 32'hBAD0_0001, 0, 0, 0);
    @(negedge clk); chk("t6_out_after", outstanding, 0); chk("t6_drop", sbr_rvalid, 0);
    cyc(); mgr_rvalid = 0;
    repeat (3) cyc();
    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
